// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one add/sub + arithmetic shift per clock on an
// A/Q/q_m1 register set, with run-time signed/unsigned operand extension.
module booth_seq_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned E  = WIDTH + 1;
    localparam int unsigned CW = $clog2(E + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [E-1:0]       a_q, a_d;
    logic [E-1:0]       q_q, q_d;
    logic [E-1:0]       m_q, m_d;
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [E-1:0]       sum;
    logic [E-1:0]       a_sh;
    logic [E-1:0]       q_sh;
    logic [E-1:0]       m_ext;
    logic [E-1:0]       q_ext;
    logic               load;

    // The extra top bit lets unsigned operands behave as non-negative Booth operands.
    assign m_ext = signed_mode ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
    assign q_ext = signed_mode ? {multiplier[WIDTH-1], multiplier} : {1'b0, multiplier};

    always_comb begin
        unique case ({q_q[0], qm1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q + ~m_q + E'(1);
            default: sum = a_q;
        endcase
        a_sh = {sum[E-1], sum[E-1:1]};
        q_sh = {sum[0], q_q[E-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        load      = 1'b0;

        unique case (state_q)
            StIdle: begin
                load = start;
            end
            StRun: begin
                a_d   = a_sh;
                q_d   = q_sh;
                qm1_d = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(E - 1)) begin
                    state_d   = StDone;
                    // Low 2*WIDTH bits of the final {A,Q}.
                    product_d = {a_sh[WIDTH-2:0], q_sh};
                end
            end
            StDone: begin
                load = start;
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            a_d     = '0;
            q_d     = q_ext;
            qm1_d   = 1'b0;
            m_d     = m_ext;
            cnt_d   = '0;
            state_d = StRun;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign product = product_q;

endmodule
